dsm_result_uploader: RTL

DSM_RESULT_UPLOADER -- requirements
Module: dsm_result_uploader

---
 rtl/dsm_pkg.sv | 20 ++
 rtl/dsm_result_uploader_if.sv | 24 ++
 rtl/dsm_rr_arbiter.sv | 35 +++
 rtl/dsm_result_uploader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dsm_pkg.sv
// dsm_pkg - shared definitions for the DSM result uploader.
//   dsm_state_e      : uploader FSM states (IDLE / LOAD / SEND)
//   FRAME_LEN_CSUM   : frame length in bytes with checksum byte
//   FRAME_LEN_PLAIN  : frame length in bytes without checksum byte
//   HEADER_DEFAULT   : default first byte of every frame
//   MEAS_W           : width of one high/low measurement count
package dsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } dsm_state_e;

  localparam int         FRAME_LEN_CSUM  = 7;
  localparam int         FRAME_LEN_PLAIN = 6;
  localparam logic [7:0] HEADER_DEFAULT  = 8'hAA;
  localparam int         MEAS_W          = 16;

endpackage

// File: rtl/dsm_result_uploader_if.sv
// dsm_result_uploader_if - byte-stream upload bus with valid/ready handshake.
//   data_out   : current frame byte (driven by master)
//   data_valid : data_out holds a valid byte (driven by master)
//   data_ready : downstream accepts the byte (driven by slave)
// A byte transfers on a clock edge where data_valid & data_ready.
interface dsm_result_uploader_if;

  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/dsm_rr_arbiter.sv
// dsm_rr_arbiter - combinational round-robin arbiter.
//   req_i       : request vector (one bit per channel)
//   start_i     : channel index searched first (the one after the last grant)
//   grant_o     : one-hot grant, all zero when no request
//   grant_idx_o : index of the granted channel (0 when no request)
module dsm_rr_arbiter #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  always_comb begin
    int  idx;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      // start_i is always < N, so one wrap subtraction is enough
      idx = int'(start_i) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dsm_result_uploader.sv
// dsm_result_uploader - captures per-channel DSM measurement results and
// uploads them as byte frames over a valid/ready stream.
//   clk, rst       : single clock, asynchronous active-high reset
//   high_time      : per-channel high counts, 16 bits per channel packed
//   low_time       : per-channel low counts, packed like high_time
//   measure_done   : per-channel completion levels (rising edge = new result)
//   up (master)    : data_out / data_valid / data_ready upload bus
//   busy           : a frame is being loaded or sent
//   overrun_cnt    : saturating count of results overwritten before upload
// Frame: HEADER_BYTE, channel, high[15:8], high[7:0], low[15:8], low[7:0]
// and, when DSM_UPLOAD_CHECKSUM_EN is defined, a checksum byte equal to the
// mod-256 sum of bytes 1..5.
//
// state   | meaning
// IDLE    | waiting for any pending result
// LOAD    | one cycle: pick channel round-robin, copy snapshot to tx buffer
// SEND    | present frame bytes, advance on data_valid & data_ready
module dsm_result_uploader
  import dsm_pkg::*;
#(
  parameter int         NUM_CHANNELS = 8,
  parameter logic [7:0] HEADER_BYTE  = HEADER_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CHANNELS*MEAS_W-1:0] high_time,
  input  logic [NUM_CHANNELS*MEAS_W-1:0] low_time,
  input  logic [NUM_CHANNELS-1:0]        measure_done,
  dsm_result_uploader_if.master          up,
  output logic                           busy,
  output logic [7:0]                     overrun_cnt
);

  localparam int IW = $clog2(NUM_CHANNELS);
`ifdef DSM_UPLOAD_CHECKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
  localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

  logic [NUM_CHANNELS-1:0] done_q;
  logic [NUM_CHANNELS-1:0] pending_q;
  logic [NUM_CHANNELS-1:0] edge_w;
  logic [NUM_CHANNELS-1:0] lost_w;
  logic                    armed_q;
  logic [MEAS_W-1:0]       snap_hi_q [NUM_CHANNELS];
  logic [MEAS_W-1:0]       snap_lo_q [NUM_CHANNELS];
  logic [7:0]              overrun_q;
  logic [7:0]              overrun_d;
  logic [4:0]              lost_cnt;
  logic [8:0]              ovr_sum;

  dsm_state_e              state_q;
  logic [IW-1:0]           rr_ptr_q;
  logic [IW-1:0]           tx_ch_q;
  logic [MEAS_W-1:0]       tx_hi_q;
  logic [MEAS_W-1:0]       tx_lo_q;
  logic [2:0]              byte_idx_q;
  logic [2:0]              byte_idx_nxt;
  logic [7:0]              data_out_q;
  logic                    data_valid_q;
  logic                    busy_q;
  logic [7:0]              next_byte;
  logic [7:0]              ch_byte;

  logic [NUM_CHANNELS-1:0] grant_w;
  logic [IW-1:0]           grant_idx_w;
  logic                    load_w;

  assign load_w = (state_q == ST_LOAD);

  // done_q is zero during reset; armed_q masks the first cycle after release
  // so that a level already high only gets sampled, never seen as an edge.
  assign edge_w = measure_done & ~done_q & {NUM_CHANNELS{armed_q}};

  // A same-cycle edge on the LOAD winner is not a loss: the old result goes
  // to the tx buffer and the new one stays pending.
  assign lost_w = edge_w & pending_q & ~(load_w ? grant_w : '0);

  always_comb begin
    lost_cnt = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      lost_cnt = lost_cnt + 5'(lost_w[i]);
    end
    ovr_sum   = {1'b0, overrun_q} + {4'b0, lost_cnt};
    overrun_d = ovr_sum[8] ? 8'hFF : ovr_sum[7:0];
  end

  dsm_rr_arbiter #(
    .N  (NUM_CHANNELS),
    .IW (IW)
  ) u_arb (
    .req_i       (pending_q),
    .start_i     (rr_ptr_q),
    .grant_o     (grant_w),
    .grant_idx_o (grant_idx_w)
  );

  // Capture: snapshot on edge; the set wins over a LOAD clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q    <= '0;
      armed_q   <= 1'b0;
      pending_q <= '0;
      overrun_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        snap_hi_q[i] <= '0;
        snap_lo_q[i] <= '0;
      end
    end else begin
      armed_q   <= 1'b1;
      done_q    <= measure_done;
      overrun_q <= overrun_d;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (edge_w[i]) begin
          snap_hi_q[i] <= high_time[i*MEAS_W +: MEAS_W];
          snap_lo_q[i] <= low_time[i*MEAS_W +: MEAS_W];
          pending_q[i] <= 1'b1;
        end else if (load_w && grant_w[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  assign ch_byte      = {{(8 - IW){1'b0}}, tx_ch_q};
  assign byte_idx_nxt = byte_idx_q + 3'd1;

  always_comb begin
    next_byte = 8'h00;
    case (byte_idx_nxt)
      3'd1: next_byte = ch_byte;
      3'd2: next_byte = tx_hi_q[15:8];
      3'd3: next_byte = tx_hi_q[7:0];
      3'd4: next_byte = tx_lo_q[15:8];
      3'd5: next_byte = tx_lo_q[7:0];
`ifdef DSM_UPLOAD_CHECKSUM_EN
      3'd6: next_byte = ch_byte + tx_hi_q[15:8] + tx_hi_q[7:0]
                      + tx_lo_q[15:8] + tx_lo_q[7:0];
`endif
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      tx_ch_q      <= '0;
      tx_hi_q      <= '0;
      tx_lo_q      <= '0;
      byte_idx_q   <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pending_q) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // snapshot read here is the pre-edge value, so a colliding
          // capture lands in the snapshot while the old result is sent
          tx_ch_q      <= grant_idx_w;
          tx_hi_q      <= snap_hi_q[grant_idx_w];
          tx_lo_q      <= snap_lo_q[grant_idx_w];
          rr_ptr_q     <= (grant_idx_w == IW'(NUM_CHANNELS - 1)) ? '0
                                                                 : grant_idx_w + 1'b1;
          byte_idx_q   <= '0;
          data_out_q   <= HEADER_BYTE;
          data_valid_q <= 1'b1;
          state_q      <= ST_SEND;
        end
        ST_SEND: begin
          if (data_valid_q && up.data_ready) begin
            if (byte_idx_q == 3'(FRAME_LEN - 1)) begin
              state_q      <= ST_IDLE;
              data_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              data_out_q   <= '0;
            end else begin
              byte_idx_q <= byte_idx_nxt;
              data_out_q <= next_byte;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          data_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign up.data_out   = data_out_q;
  assign up.data_valid = data_valid_q;
  assign busy          = busy_q;
  assign overrun_cnt   = overrun_q;

endmodule
